// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin arbiter that wraps channel byte streams into SYNC/ID/payload frames for the UART TX FIFO.
// Define UART_TX_ARB_CSUM_EN to append an 8-bit additive checksum (ID + payload) to every frame.
module uart_tx_frame_arbiter #(
    parameter int          NUM_CH    = 4,
    parameter int          MAX_LEN   = 32,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_CH-1:0]     ch_valid,
    input  logic [8*NUM_CH-1:0]   ch_data,
    input  logic [NUM_CH-1:0]     ch_last,
    output logic [NUM_CH-1:0]     ch_ready,
    input  logic                  fifo_full,
    output logic                  wr_en,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic [2:0]            grant_id,
    output logic                  trunc_err,
    input  logic                  err_clr
);

`ifdef UART_TX_ARB_CSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ID, S_PAYLOAD, S_CSUM} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ID, S_PAYLOAD} state_e;
`endif

    state_e            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        grant_q, grant_d;
    logic [7:0]        len_q, len_d;
    logic              trunc_q, trunc_d;
`ifdef UART_TX_ARB_CSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic [2*NUM_CH-1:0] valid_rot;
    logic                sel_found;
    logic [2:0]          sel_idx;
    logic                g_valid, g_last;
    logic [7:0]          g_data;
    logic [2:0]          ptr_next;

    assign ptr_next = (grant_q == 3'(NUM_CH - 1)) ? 3'd0 : grant_q + 3'd1;

    // Rotate the request vector so bit 0 is the channel at ptr; the first set bit wins.
    always_comb begin
        valid_rot = {ch_valid, ch_valid} >> ptr_q;
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!sel_found && valid_rot[k]) begin
                sel_found = 1'b1;
                sel_idx   = 3'((int'(ptr_q) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == 3'(i)) begin
                g_valid = ch_valid[i];
                g_last  = ch_last[i];
                g_data  = ch_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        len_d    = len_q;
        trunc_d  = trunc_q;
`ifdef UART_TX_ARB_CSUM_EN
        csum_d   = csum_q;
`endif
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        ch_ready = '0;

        // Clear first so a truncation in the same cycle overrides it.
        if (err_clr) trunc_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en && sel_found) begin
                    grant_d = sel_idx;
                    len_d   = 8'd0;
`ifdef UART_TX_ARB_CSUM_EN
                    csum_d  = 8'h00;
`endif
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                if (!fifo_full) begin
                    wr_en   = 1'b1;
                    wr_data = SYNC_BYTE;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (!fifo_full) begin
                    wr_en   = 1'b1;
                    wr_data = {5'b0, grant_q};
`ifdef UART_TX_ARB_CSUM_EN
                    csum_d  = {5'b0, grant_q};
`endif
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    ch_ready[i] = (grant_q == 3'(i)) && ch_valid[i] && !fifo_full;
                end
                if (g_valid && !fifo_full) begin
                    wr_en   = 1'b1;
                    wr_data = g_data;
                    len_d   = len_q + 8'd1;
`ifdef UART_TX_ARB_CSUM_EN
                    csum_d  = csum_q + g_data;
`endif
                    if (g_last || (len_q == 8'(MAX_LEN - 1))) begin
                        if (!g_last) trunc_d = 1'b1;
`ifdef UART_TX_ARB_CSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_IDLE;
                        ptr_d   = ptr_next;
`endif
                    end
                end
            end
`ifdef UART_TX_ARB_CSUM_EN
            S_CSUM: begin
                if (!fifo_full) begin
                    wr_en   = 1'b1;
                    wr_data = csum_q;
                    state_d = S_IDLE;
                    ptr_d   = ptr_next;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 3'd0;
            grant_q <= 3'd0;
            len_q   <= 8'd0;
            trunc_q <= 1'b0;
`ifdef UART_TX_ARB_CSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
`ifdef UART_TX_ARB_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign grant_id  = grant_q;
    assign trunc_err = trunc_q;

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Directed bench for uart_tx_frame_arbiter (NUM_CH=4, MAX_LEN=4); follows UART_TX_ARB_CSUM_EN like the RTL.
module tb_uart_tx_frame_arbiter;

    localparam int N = 4;
`ifdef UART_TX_ARB_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic           clk, rst_n, en, fifo_full, err_clr;
    logic [N-1:0]   ch_valid, ch_last, ch_ready;
    logic [8*N-1:0] ch_data;
    logic           wr_en, busy, trunc_err;
    logic [7:0]     wr_data;
    logic [2:0]     grant_id;

    uart_tx_frame_arbiter #(.NUM_CH(N), .MAX_LEN(4), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_last(ch_last), .ch_ready(ch_ready),
        .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data),
        .busy(busy), .grant_id(grant_id), .trunc_err(trunc_err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-channel sources: {last, data}; head is presented while non-empty.
    logic [8:0] src_q [N][$];
    logic [N-1:0] rdy_s;

    initial begin
        ch_valid = '0; ch_last = '0; ch_data = '0;
        forever begin
            @(negedge clk);
            rdy_s = ch_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (rdy_s[i] && rst_n && src_q[i].size() > 0) void'(src_q[i].pop_front());
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    ch_valid[i]       = 1'b1;
                    ch_last[i]        = src_q[i][0][8];
                    ch_data[8*i +: 8] = src_q[i][0][7:0];
                end else begin
                    ch_valid[i]       = 1'b0;
                    ch_last[i]        = 1'b0;
                    ch_data[8*i +: 8] = 8'h00;
                end
            end
        end
    end

    // Monitor: FIFO writes, grant per frame, completed frames, busy cycles.
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    logic [2:0] grants[$];
    int frames_done = 0;
    int busy_cycles = 0;
    logic busy_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && wr_en) cap.push_back(wr_data);
            if (busy && !busy_prev) grants.push_back(grant_id);
            if (!busy && busy_prev) frames_done++;
            if (busy) busy_cycles++;
            busy_prev = busy;
        end
    end

    task automatic mon_clear();
        cap.delete();
        exp_q.delete();
        grants.delete();
        frames_done = 0;
        busy_cycles = 0;
    endtask

    task automatic push(input int ch, input logic [7:0] d, input logic last);
        src_q[ch].push_back({last, d});
    endtask

    // Expected frame: payload packed MSB-first in pl, n bytes; cs is the hand-computed checksum.
    task automatic fr(input logic [2:0] id, input logic [47:0] pl, input int n, input logic [7:0] cs);
        exp_q.push_back(8'hA5);
        exp_q.push_back({5'b0, id});
        for (int i = 0; i < n; i++) exp_q.push_back(pl[8*(n-1-i) +: 8]);
        if (CSUM) exp_q.push_back(cs);
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_len"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            check($sformatf("%s[%0d]", tag, i), cap[i], exp_q[i]);
    endtask

    task automatic wait_frames(input int n);
        int cyc = 0;
        while (frames_done < n && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check("frames_done", frames_done, n);
    endtask

    task automatic wait_writes(input int n);
        int cyc = 0;
        while (cap.size() < n && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("writes_seen", cap.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; fifo_full = 1'b0; err_clr = 1'b0;
        #12;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_ch_ready", ch_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_trunc", trunc_err, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // en low: pending request must not be granted
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("en_low_busy", busy, 0);
        check("en_low_writes", cap.size(), 0);

        // ch0 3-byte frame; csum 00+01+02+03 = 06
        mon_clear();
        en = 1'b1;
        fr(3'd0, 48'h010203, 3, 8'h06);
        wait_frames(1);
        cmp_stream("basic");
        check("basic_busy_cycles", busy_cycles, CSUM ? 6 : 5);
        check("basic_src_drained", src_q[0].size(), 0);

        // ch1 and ch3 from ptr=0 -> grants 1,3,1
        do_reset();
        mon_clear();
        push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b1); push(1, 8'h12, 1'b1);
        push(3, 8'h30, 1'b1);
        fr(3'd1, 48'h1011, 2, 8'h22);
        fr(3'd3, 48'h30, 1, 8'h33);
        fr(3'd1, 48'h12, 1, 8'h13);
        wait_frames(3);
        check("rr_ngrants", grants.size(), 3);
        if (grants.size() == 3) begin
            check("rr_grant0", grants[0], 1);
            check("rr_grant1", grants[1], 3);
            check("rr_grant2", grants[2], 1);
        end
        cmp_stream("rr");

        // FIFO full stall for 5 cycles mid-payload; last exactly at MAX_LEN is not a truncation
        mon_clear();
        push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b0); push(0, 8'h44, 1'b1);
        fr(3'd0, 48'h41424344, 4, 8'h0A);
        wait_writes(3);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_wr_en%0d", i), wr_en, 0);
            check($sformatf("stall_ready%0d", i), ch_ready, 0);
        end
        @(posedge clk); #1 fifo_full = 1'b0;
        wait_frames(1);
        cmp_stream("stall");
        check("stall_no_trunc", trunc_err, 0);

        // Truncation at MAX_LEN=4: 6 bytes -> 4 + 2; csums 02+51..54=4C, 02+55+56=AD
        mon_clear();
        for (int i = 0; i < 5; i++) push(2, 8'h51 + 8'(i), 1'b0);
        push(2, 8'h56, 1'b1);
        fr(3'd2, 48'h51525354, 4, 8'h4C);
        fr(3'd2, 48'h5556, 2, 8'hAD);
        wait_frames(2);
        cmp_stream("trunc");
        check("trunc_ngrants", grants.size(), 2);
        check("trunc_set", trunc_err, 1);
        check("trunc_src_drained", src_q[2].size(), 0);
        err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        check("trunc_cleared", trunc_err, 0);

        // Async reset during payload byte 2 of a ch3 frame (ptr=3 beforehand)
        mon_clear();
        push(3, 8'h61, 1'b0); push(3, 8'h62, 1'b0); push(3, 8'h63, 1'b1);
        wait_writes(3);
        check("pre_rst_grant", grant_id, 3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr_en", wr_en, 0);
        check("arst_wr_data", wr_data, 0);
        check("arst_ch_ready", ch_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_grant", grant_id, 0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_clear();
        push(1, 8'h70, 1'b1); push(3, 8'h72, 1'b1);
        fr(3'd1, 48'h70, 1, 8'h71);
        fr(3'd3, 48'h72, 1, 8'h75);
        wait_frames(2);
        check("post_rst_ngrants", grants.size(), 2);
        if (grants.size() == 2) begin
            check("post_rst_grant0", grants[0], 1);
            check("post_rst_grant1", grants[1], 3);
        end
        cmp_stream("post_rst");

        // Single byte FF on ch0: csum 00+FF = FF when present
        mon_clear();
        push(0, 8'hFF, 1'b1);
        fr(3'd0, 48'hFF, 1, 8'hFF);
        wait_frames(1);
        cmp_stream("single");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
